// File: rtl/and_gate_checker_if.sv
// Stimulus/response bundle between the gate checker and the gate under test,
// plus the run control and result signals.
interface and_gate_checker_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             A;
    logic             B;
    logic             Y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       first_fail;

    modport master (
        input  start, Y,
        output A, B, busy, done, pass, err_count, first_fail
    );

    modport slave (
        output start, Y,
        input  A, B, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/and_gate_checker.sv
// Hardware checker for a 2-input gate: sweeps {A,B}, samples Y after a settle
// window, compares with EXPECT_TT. Optional CHECKER_STOP_ON_FAIL_EN ends the run on the first mismatch.
module and_gate_checker #(
    parameter int             SETTLE_CYCLES = 2,
    parameter int             NUM_PASSES    = 1,
    parameter logic [3:0]     EXPECT_TT     = 4'b1000,
    parameter int             ERR_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    and_gate_checker_if.master   bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       PASS_LAST   = 4'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           state, state_n;
    logic [1:0]       vec, vec_n;
    logic [7:0]       settle_cnt, settle_n;
    logic [3:0]       pass_cnt, pcnt_n;
    logic             a_q, a_n, b_q, b_n;
    logic             busy_q, busy_n, done_q, done_n, pass_q, pass_n;
    logic [ERR_W-1:0] err_q, err_n;
    logic [1:0]       ff_q, ff_n;
    logic             mismatch, last_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ff_q       <= '0;
        end else begin
            state      <= state_n;
            vec        <= vec_n;
            settle_cnt <= settle_n;
            pass_cnt   <= pcnt_n;
            a_q        <= a_n;
            b_q        <= b_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            pass_q     <= pass_n;
            err_q      <= err_n;
            ff_q       <= ff_n;
        end
    end

    always_comb begin
        state_n  = state;
        vec_n    = vec;
        settle_n = settle_cnt;
        pcnt_n   = pass_cnt;
        a_n      = a_q;
        b_n      = b_q;
        busy_n   = busy_q;
        done_n   = done_q;
        pass_n   = pass_q;
        err_n    = err_q;
        ff_n     = ff_q;
        last_vec = 1'b0;
        mismatch = (bus.Y != EXPECT_TT[vec]);

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    vec_n    = '0;
                    settle_n = '0;
                    pcnt_n   = '0;
                    err_n    = '0;
                    ff_n     = '0;
                    done_n   = 1'b0;
                    pass_n   = 1'b0;
                    busy_n   = 1'b1;
                    a_n      = 1'b0;
                    b_n      = 1'b0;
                    state_n  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_n = '0;
                    state_n  = SAMPLE;
                end else begin
                    settle_n = settle_cnt + 8'd1;
                end
            end
            SAMPLE: begin
                // err_count never returns to zero within a run, so zero marks "no mismatch yet"
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_n = err_q + 1'b1;
                    if (err_q == '0)      ff_n  = vec;
                end
`ifdef CHECKER_STOP_ON_FAIL_EN
                last_vec = mismatch || (vec == 2'd3 && pass_cnt == PASS_LAST);
`else
                last_vec = (vec == 2'd3 && pass_cnt == PASS_LAST);
`endif
                if (last_vec) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_n == '0);
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    state_n = DONE;
                end else begin
                    // vector index wraps 3 -> 0 at the start of the next pass
                    vec_n      = vec + 2'd1;
                    {a_n, b_n} = vec + 2'd1;
                    if (vec == 2'd3) pcnt_n = pass_cnt + 4'd1;
                    state_n    = SETTLE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
endmodule
